// File: rtl/icache_txreq_sched_pkg.sv
// Shared types and constants for the icache downstream request scheduler.
// Imported by the scheduler top and its arbiter.
package icache_txreq_sched_pkg;

  localparam int MSHR_ENTRY_INDEX_WIDTH = 3;
  localparam int ENTRY_NUM = 1 << MSHR_ENTRY_INDEX_WIDTH;
  localparam int ICACHE_TXREQ_CREDIT_NUM = 4;
  localparam int ICACHE_PF_STARVE_LIMIT = 4;
  localparam int PC_W = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
  } pc_req_t;

  typedef enum logic {
    TXREQ_SRC_DEMAND,
    TXREQ_SRC_PF
  } txreq_src_e;

endpackage

// File: rtl/icache_rr_arb.sv
// Rotating-priority one-hot picker: first set request
// at or after ptr, wrapping from N-1 back to 0.
module icache_rr_arb #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic         found;
  logic [W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/icache_txreq_sched.sv
// Schedules MSHR demand misses and prefetches onto one downstream
// request channel with credits, round-robin and prefetch starve guard.
module icache_txreq_sched
  import icache_txreq_sched_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              prefetch_enable,
  input  logic [ENTRY_NUM-1:0]              mshr_req_vld,
  input  pc_req_t                           mshr_req_pld [ENTRY_NUM],
  output logic [ENTRY_NUM-1:0]              mshr_req_ack,
  input  logic                              pf_req_vld,
  output logic                              pf_req_rdy,
  input  pc_req_t                           pf_req_pld,
  input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] pf_req_entry_id,
  input  logic                              credit_return,
  output logic                              downstream_txreq_vld,
  input  logic                              downstream_txreq_rdy,
  output pc_req_t                           downstream_txreq_pld,
  output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] downstream_txreq_entry_id
);

  localparam int IW = MSHR_ENTRY_INDEX_WIDTH;
  localparam int CW = $clog2(ICACHE_TXREQ_CREDIT_NUM + 1);
  localparam int SW = $clog2(ICACHE_PF_STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(ICACHE_TXREQ_CREDIT_NUM);
  localparam logic [SW-1:0] STARVE_MAX = SW'(ICACHE_PF_STARVE_LIMIT);

  logic                 txreq_vld_q, txreq_vld_d;
  pc_req_t              txreq_pld_q, txreq_pld_d;
  logic [IW-1:0]        txreq_id_q, txreq_id_d;
  logic [CW-1:0]        credit_cnt_q, credit_cnt_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
  logic [ENTRY_NUM-1:0] ack_q, ack_d;

  logic [ENTRY_NUM-1:0] dmd_req;
  logic [ENTRY_NUM-1:0] dmd_gnt;
  logic [IW-1:0]        dmd_idx;
  logic                 demand;
  logic                 pf;
  logic                 load_en;
  txreq_src_e           src;

  // Last-acked entry is masked one cycle while its requester drops vld.
  assign dmd_req = mshr_req_vld & ~ack_q;

  icache_rr_arb #(
    .N (ENTRY_NUM),
    .W (IW)
  ) u_rr_arb (
    .req     (dmd_req),
    .ptr     (rr_ptr_q),
    .gnt     (dmd_gnt),
    .gnt_idx (dmd_idx)
  );

  always_comb begin
    demand  = |dmd_req;
    pf      = pf_req_vld & prefetch_enable;
    load_en = rst_n
            & (!txreq_vld_q | downstream_txreq_rdy)
            & (credit_cnt_q != '0)
            & (demand | pf);
    src = TXREQ_SRC_DEMAND;
    if (pf && (starve_cnt_q == STARVE_MAX || !demand))
      src = TXREQ_SRC_PF;

    mshr_req_ack = '0;
    pf_req_rdy   = 1'b0;
    txreq_vld_d  = txreq_vld_q & ~downstream_txreq_rdy;
    txreq_pld_d  = txreq_pld_q;
    txreq_id_d   = txreq_id_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;

    if (load_en) begin
      txreq_vld_d = 1'b1;
      if (src == TXREQ_SRC_PF) begin
        pf_req_rdy  = 1'b1;
        txreq_pld_d = pf_req_pld;
        txreq_id_d  = pf_req_entry_id;
      end else begin
        mshr_req_ack = dmd_gnt;
        txreq_pld_d  = mshr_req_pld[dmd_idx];
        txreq_id_d   = dmd_idx;
        rr_ptr_d     = dmd_idx + IW'(1);
      end
    end

    if (!pf || pf_req_rdy)
      starve_cnt_d = '0;
    else if (load_en && starve_cnt_q != STARVE_MAX)
      starve_cnt_d = starve_cnt_q + SW'(1);

    ack_d = mshr_req_ack;

    unique case ({load_en, credit_return})
      2'b10:   credit_cnt_d = credit_cnt_q - CW'(1);
      2'b01:   credit_cnt_d = (credit_cnt_q == CREDIT_MAX) ?
                              credit_cnt_q : credit_cnt_q + CW'(1);
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txreq_vld_q  <= 1'b0;
      txreq_pld_q  <= '0;
      txreq_id_q   <= '0;
      credit_cnt_q <= CREDIT_MAX;
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
      ack_q        <= '0;
    end else begin
      txreq_vld_q  <= txreq_vld_d;
      txreq_pld_q  <= txreq_pld_d;
      txreq_id_q   <= txreq_id_d;
      credit_cnt_q <= credit_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      ack_q        <= ack_d;
    end
  end

  assign downstream_txreq_vld      = txreq_vld_q;
  assign downstream_txreq_pld      = txreq_pld_q;
  assign downstream_txreq_entry_id = txreq_id_q;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    txreq_vld_q && !downstream_txreq_rdy |=>
      txreq_vld_q && $stable(txreq_pld_q) && $stable(txreq_id_q));

  a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(mshr_req_ack));

  a_no_load_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(load_en && credit_cnt_q == '0));

  a_ret_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(credit_return && credit_cnt_q == CREDIT_MAX));

endmodule

// File: tb/tb_icache_txreq_sched.sv
// Directed self-checking bench for icache_txreq_sched.
// Expected values are hand-derived per scenario.
module tb_icache_txreq_sched;
  import icache_txreq_sched_pkg::*;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic                              prefetch_enable;
  logic [ENTRY_NUM-1:0]              mshr_req_vld;
  pc_req_t                           mshr_req_pld [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]              mshr_req_ack;
  logic                              pf_req_vld;
  logic                              pf_req_rdy;
  pc_req_t                           pf_req_pld;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] pf_req_entry_id;
  logic                              credit_return;
  logic                              downstream_txreq_vld;
  logic                              downstream_txreq_rdy;
  pc_req_t                           downstream_txreq_pld;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] downstream_txreq_entry_id;

  int  n_chk  = 0;
  int  n_pass = 0;
  logic auto_ret;
  logic hs;

  icache_txreq_sched dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .prefetch_enable           (prefetch_enable),
    .mshr_req_vld              (mshr_req_vld),
    .mshr_req_pld              (mshr_req_pld),
    .mshr_req_ack              (mshr_req_ack),
    .pf_req_vld                (pf_req_vld),
    .pf_req_rdy                (pf_req_rdy),
    .pf_req_pld                (pf_req_pld),
    .pf_req_entry_id           (pf_req_entry_id),
    .credit_return             (credit_return),
    .downstream_txreq_vld      (downstream_txreq_vld),
    .downstream_txreq_rdy      (downstream_txreq_rdy),
    .downstream_txreq_pld      (downstream_txreq_pld),
    .downstream_txreq_entry_id (downstream_txreq_entry_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  // A downstream completion is returned the cycle after its handshake.
  task automatic tick();
    hs = downstream_txreq_vld && downstream_txreq_rdy;
    @(posedge clk);
    #1;
    credit_return = auto_ret && hs;
    #1;
  endtask

  task automatic do_reset();
    rst_n                = 1'b0;
    mshr_req_vld         = '0;
    pf_req_vld           = 1'b0;
    prefetch_enable      = 1'b1;
    credit_return        = 1'b0;
    downstream_txreq_rdy = 1'b1;
    auto_ret             = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] pc_of(input int e);
    return 32'h1000 + 32'(e * 64);
  endfunction

  initial begin
    int d;
    logic isp;
    for (int i = 0; i < ENTRY_NUM; i++) mshr_req_pld[i].pc = pc_of(i);
    pf_req_pld.pc   = 32'hBEEF0;
    pf_req_entry_id = 3'd6;

    // Reset, then async reset while a request is held
    rst_n                = 1'b0;
    mshr_req_vld         = '0;
    pf_req_vld           = 1'b0;
    prefetch_enable      = 1'b1;
    credit_return        = 1'b0;
    downstream_txreq_rdy = 1'b1;
    auto_ret             = 1'b1;
    tick();
    tick();
    chk("rst_vld", 64'(downstream_txreq_vld), 64'd0);
    chk("rst_id", 64'(downstream_txreq_entry_id), 64'd0);
    chk("rst_pld", 64'(downstream_txreq_pld.pc), 64'd0);
    chk("rst_pfrdy", 64'(pf_req_rdy), 64'd0);
    mshr_req_vld = 8'h08;
    #1;
    chk("rst_ack", 64'(mshr_req_ack), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_credit", 64'(dut.credit_cnt_q), 64'd4);
    chk("rel_ack", 64'(mshr_req_ack), 64'h08);
    downstream_txreq_rdy = 1'b0;
    tick();
    mshr_req_vld = '0;
    chk("ld_vld", 64'(downstream_txreq_vld), 64'd1);
    chk("ld_id", 64'(downstream_txreq_entry_id), 64'd3);
    tick();
    chk("hold_vld", 64'(downstream_txreq_vld), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld", 64'(downstream_txreq_vld), 64'd0);
    do_reset();
    chk("rst2_credit", 64'(dut.credit_cnt_q), 64'd4);

    // Round-robin over all entries, full throughput
    mshr_req_vld = 8'hFF;
    #1;
    for (int k = 0; k < 9; k++) begin
      chk("rr_ack", 64'(mshr_req_ack), 64'(1 << (k % 8)));
      tick();
      chk("rr_vld", 64'(downstream_txreq_vld), 64'd1);
      chk("rr_id", 64'(downstream_txreq_entry_id), 64'(k % 8));
    end
    mshr_req_vld = '0;

    // Backpressure with entry 3 in the slot
    do_reset();
    mshr_req_vld = 8'h08;
    downstream_txreq_rdy = 1'b0;
    #1;
    chk("bp_ack0", 64'(mshr_req_ack), 64'h08);
    tick();
    mshr_req_vld = 8'h30;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld", 64'(downstream_txreq_vld), 64'd1);
      chk("bp_id", 64'(downstream_txreq_entry_id), 64'd3);
      chk("bp_pld", 64'(downstream_txreq_pld.pc), 64'(pc_of(3)));
      chk("bp_noack", 64'(mshr_req_ack), 64'd0);
      tick();
    end
    downstream_txreq_rdy = 1'b1;
    #1;
    chk("bp_ack1", 64'(mshr_req_ack), 64'h10);
    tick();
    chk("bp_next_id", 64'(downstream_txreq_entry_id), 64'd4);
    chk("bp_next_pld", 64'(downstream_txreq_pld.pc), 64'(pc_of(4)));
    mshr_req_vld = '0;

    // Credit exhaustion and return
    do_reset();
    auto_ret = 1'b0;
    mshr_req_vld = 8'h3F;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("cr_ack", 64'(mshr_req_ack), (k < 4) ? 64'(1 << k) : 64'd0);
      tick();
    end
    chk("cr_zero", 64'(dut.credit_cnt_q), 64'd0);
    credit_return = 1'b1;
    #1;
    chk("cr_ret_noload", 64'(mshr_req_ack), 64'd0);
    tick();
    chk("cr_one_ack", 64'(mshr_req_ack), 64'h10);
    tick();
    chk("cr_stall_ack", 64'(mshr_req_ack), 64'd0);
    chk("cr_zero2", 64'(dut.credit_cnt_q), 64'd0);
    credit_return = 1'b1;
    tick();
    chk("cr_ack5", 64'(mshr_req_ack), 64'h20);
    credit_return = 1'b1;
    #1;
    tick();
    chk("cr_same", 64'(dut.credit_cnt_q), 64'd1);
    chk("cr_wrap_ack", 64'(mshr_req_ack), 64'h01);
    mshr_req_vld = '0;

    // Prefetch starvation guard
    do_reset();
    mshr_req_vld    = 8'hFF;
    pf_req_vld      = 1'b1;
    pf_req_entry_id = 3'd6;
    #1;
    d = 0;
    for (int k = 0; k < 10; k++) begin
      isp = ((k % 5) == 4);
      chk("sv_pfrdy", 64'(pf_req_rdy), 64'(isp));
      chk("sv_ack", 64'(mshr_req_ack), isp ? 64'd0 : 64'(1 << d));
      tick();
      chk("sv_id", 64'(downstream_txreq_entry_id), isp ? 64'd6 : 64'(d));
      if (!isp) d++;
    end
    prefetch_enable = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("pfdis_rdy", 64'(pf_req_rdy), 64'd0);
      tick();
    end
    mshr_req_vld = '0;
    pf_req_vld   = 1'b0;

    // Prefetch only, then a held prefetch survives disable
    do_reset();
    pf_req_vld      = 1'b1;
    pf_req_entry_id = 3'd5;
    #1;
    chk("pfo_rdy", 64'(pf_req_rdy), 64'd1);
    chk("pfo_ack", 64'(mshr_req_ack), 64'd0);
    downstream_txreq_rdy = 1'b0;
    tick();
    pf_req_vld      = 1'b0;
    prefetch_enable = 1'b0;
    chk("pfo_vld", 64'(downstream_txreq_vld), 64'd1);
    chk("pfo_id", 64'(downstream_txreq_entry_id), 64'd5);
    chk("pfo_pld", 64'(downstream_txreq_pld.pc), 64'hBEEF0);
    tick();
    chk("pfo_held", 64'(downstream_txreq_vld), 64'd1);
    downstream_txreq_rdy = 1'b1;
    tick();
    chk("pfo_done", 64'(downstream_txreq_vld), 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
